// File: rtl/counter_pkg.sv
// Shared types for the event counters: counting modes and the run-control FSM states.
package counter_pkg;

    typedef enum logic [1:0] {
        CNT_FREE    = 2'b00,
        CNT_RELOAD  = 2'b01,
        CNT_ONESHOT = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // The unused encoding 2'b11 behaves as free-running wrap.
    function automatic mode_t to_mode(input logic [1:0] m);
        mode_t r;
        case (m)
            2'b01:   r = CNT_RELOAD;
            2'b10:   r = CNT_ONESHOT;
            default: r = CNT_FREE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/trigger_fall_detect.sv
// Two-flop synchronizer for the asynchronous trigger plus a delayed copy;
// emits a one-cycle pulse on each synchronized falling edge.
module trigger_fall_detect (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    output logic fall
);

    // [0] and [1] form the synchronizer, [2] is the delayed copy for edge detection.
    logic [2:0] chain_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= 3'b000;
        end else begin
            chain_q <= {chain_q[1:0], trigger};
        end
    end

    assign fall = chain_q[2] & ~chain_q[1];

endmodule

// File: rtl/sync_down_counter.sv
// Loadable down counter of trigger falling edges with free-running, auto-reload
// and one-shot modes and a single-cycle underflow pulse.
module sync_down_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [1:0]       mode,
    input  logic             start,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             underflow,
    output logic             busy
);

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             underflow_q, underflow_d;
    logic             fall;

    trigger_fall_detect u_fall (
        .clk     (clk),
        .rst     (rst),
        .trigger (trigger),
        .fall    (fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= CNT_FREE;
            count_q     <= '0;
            reload_q    <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        count_d     = count_q;
        reload_d    = reload_q;
        underflow_d = 1'b0;

        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = S_IDLE;
        end else if (start && (state_q != S_RUN)) begin
            // Restarting after a one-shot rearms from the reload register.
            state_d = S_RUN;
            mode_d  = to_mode(mode);
            if (state_q == S_DONE) begin
                count_d = reload_q;
            end
        end else if (fall && (state_q == S_RUN)) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else begin
                underflow_d = 1'b1;
                case (mode_q)
                    CNT_RELOAD:  count_d = reload_q;
                    CNT_ONESHOT: state_d = S_DONE;
                    default:     count_d = '1;
                endcase
            end
        end
    end

    assign count     = count_q;
    assign zero      = (count_q == '0);
    assign underflow = underflow_q;
    assign busy      = (state_q == S_RUN);

endmodule

// File: tb/tb_sync_down_counter.sv
// Self-checking bench for sync_down_counter: expectations are queued when stimulus
// is applied and compared when the counter is due to respond.
module tb_sync_down_counter;

    typedef struct {
        logic [3:0] cnt;
        logic       uf;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trigger = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;
    logic [1:0] mode = 2'b00;
    logic       start = 1'b0;
    logic [3:0] count;
    logic       zero;
    logic       underflow;
    logic       busy;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_pass = 0;

    sync_down_counter #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .trigger    (trigger),
        .load       (load),
        .load_value (load_value),
        .mode       (mode),
        .start      (start),
        .count      (count),
        .zero       (zero),
        .underflow  (underflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [3:0] c, input logic u, input logic b);
        exp_t e;
        e.cnt  = c;
        e.uf   = u;
        e.busy = b;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic sb_pop_compare();
        exp_t  e;
        string t;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".count"}, count, e.cnt);
        check({t, ".zero"}, zero, (e.cnt == 4'd0));
        check({t, ".underflow"}, underflow, e.uf);
        check({t, ".busy"}, busy, e.busy);
        $display("txn %-14s count=%0d zero=%0d underflow=%0d busy=%0d", t, count, zero, underflow, busy);
    endtask

    // One falling edge of trigger; the response appears two edges after it is first sampled.
    task automatic fall_edge(input string tag, input logic [3:0] c, input logic u, input logic b);
        sb_push(tag, c, u, b);
        @(negedge clk) trigger = 1'b0;
        repeat (3) @(posedge clk);
        #1 sb_pop_compare();
        if (u) begin
            @(posedge clk);
            #1 check({tag, ".uf_one_cycle"}, underflow, 0);
        end
        @(negedge clk) trigger = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_load(input string tag, input logic [3:0] v);
        sb_push(tag, v, 1'b0, 1'b0);
        @(negedge clk) begin
            load = 1'b1;
            load_value = v;
        end
        @(negedge clk) load = 1'b0;
        sb_pop_compare();
    endtask

    task automatic do_start(input string tag, input logic [1:0] m, input logic [3:0] c);
        sb_push(tag, c, 1'b0, 1'b1);
        @(negedge clk) begin
            start = 1'b1;
            mode = m;
        end
        @(negedge clk) start = 1'b0;
        sb_pop_compare();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] free_seq [7] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14};

        // Reset for two cycles with trigger held low.
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        sb_push("reset", 4'd0, 1'b0, 1'b0);
        sb_pop_compare();
        trigger = 1'b1;
        repeat (5) @(negedge clk);
        sb_push("rise_no_event", 4'd0, 1'b0, 1'b0);
        sb_pop_compare();

        // Free-running wrap.
        do_load("free_load", 4'd5);
        do_start("free_start", 2'b00, 4'd5);
        for (int i = 0; i < 7; i++) begin
            fall_edge($sformatf("free_ev%0d", i + 1), free_seq[i], (i == 5), 1'b1);
        end

        // Auto-reload.
        do_load("rld_load", 4'd3);
        do_start("rld_start", 2'b01, 4'd3);
        fall_edge("rld_ev1", 4'd2, 1'b0, 1'b1);
        fall_edge("rld_ev2", 4'd1, 1'b0, 1'b1);
        fall_edge("rld_ev3", 4'd0, 1'b0, 1'b1);
        fall_edge("rld_ev4", 4'd3, 1'b1, 1'b1);

        // One-shot, then restart from the reload register.
        do_load("os_load", 4'd2);
        do_start("os_start", 2'b10, 4'd2);
        fall_edge("os_ev1", 4'd1, 1'b0, 1'b1);
        fall_edge("os_ev2", 4'd0, 1'b0, 1'b1);
        fall_edge("os_ev3", 4'd0, 1'b1, 1'b0);
        fall_edge("os_ev4", 4'd0, 1'b0, 1'b0);
        fall_edge("os_ev5", 4'd0, 1'b0, 1'b0);
        do_start("os_restart", 2'b10, 4'd2);

        // Load coinciding with a fall pulse wins and drops the event.
        do_load("coll_load7", 4'd7);
        do_start("coll_start", 2'b00, 4'd7);
        fall_edge("coll_ev1", 4'd6, 1'b0, 1'b1);
        sb_push("coll_load9", 4'd9, 1'b0, 1'b0);
        @(negedge clk) trigger = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) begin
            load = 1'b1;
            load_value = 4'd9;
        end
        @(negedge clk) load = 1'b0;
        sb_pop_compare();
        @(negedge clk) trigger = 1'b1;
        repeat (4) @(negedge clk);
        sb_push("coll_after", 4'd9, 1'b0, 1'b0);
        sb_pop_compare();

        // Reset mid-run, then events are ignored.
        do_start("rst_start", 2'b00, 4'd9);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        sb_push("rst_mid", 4'd0, 1'b0, 1'b0);
        sb_pop_compare();
        fall_edge("rst_ev1", 4'd0, 1'b0, 1'b0);
        fall_edge("rst_ev2", 4'd0, 1'b0, 1'b0);

        // Mode 2'b11 behaves as free-running wrap.
        do_load("m3_load", 4'd0);
        do_start("m3_start", 2'b11, 4'd0);
        fall_edge("m3_ev1", 4'd15, 1'b1, 1'b1);
        fall_edge("m3_ev2", 4'd14, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
